// File: rtl/pi_controller_sat.sv
`default_nettype none
// ============================================================================
//  Module   : pi_controller_sat
//  Purpose  : Three-stage pipelined PI controller with a saturating integrator
//             and a clamped output with saturation flags. It sits between the
//             error subtractor and the actuator stage.
//  Option   : define PI_ANTIWINDUP_EN to enable conditional-integration
//             anti-windup. The integrator holds while the output is pinned
//             and the new increment pushes further into the clamp.
//  Revision : 1.0 - initial release
// ============================================================================
module pi_controller_sat #(
  parameter int DATA_W = 32,
  parameter int COEF_W = 16,
  parameter int FRAC_W = 8,
  parameter int ACC_W  = 48,
  parameter logic signed [DATA_W-1:0] OUT_MAX = {1'b0, {(DATA_W-1){1'b1}}},
  parameter logic signed [DATA_W-1:0] OUT_MIN = {1'b1, {(DATA_W-1){1'b0}}}
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic signed [DATA_W-1:0] error,
  input  logic signed [COEF_W-1:0] kp,
  input  logic signed [COEF_W-1:0] ki,
  input  logic                     clear_int,
  output logic                     out_valid,
  output logic signed [DATA_W-1:0] out,
  output logic                     sat_hi,
  output logic                     sat_lo
);

  localparam int PROD_W = DATA_W + COEF_W;
  localparam int SUM_W  = ACC_W + 1;

  localparam logic signed [ACC_W-1:0] C_ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] C_ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
  localparam logic signed [SUM_W-1:0] C_OUT_MAX_X = SUM_W'(OUT_MAX);
  localparam logic signed [SUM_W-1:0] C_OUT_MIN_X = SUM_W'(OUT_MIN);

  // ---------------------------------------------------------------- stage 1
  logic signed [PROD_W-1:0] w_err_x;
  logic signed [PROD_W-1:0] w_kp_x;
  logic signed [PROD_W-1:0] w_ki_x;
  logic signed [PROD_W-1:0] p_prod_d, i_prod_d;
  logic signed [PROD_W-1:0] p_prod_q, i_prod_q;
  logic                     v1_q;

  assign w_err_x  = PROD_W'(error);
  assign w_kp_x   = PROD_W'(kp);
  assign w_ki_x   = PROD_W'(ki);
  assign p_prod_d = w_err_x * w_kp_x;
  assign i_prod_d = w_err_x * w_ki_x;

  // Capture full-precision products; gains only matter on a valid sample.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1_q     <= 1'b0;
      p_prod_q <= '0;
      i_prod_q <= '0;
    end else begin
      v1_q <= in_valid;
      if (in_valid) begin
        p_prod_q <= p_prod_d;
        i_prod_q <= i_prod_d;
      end
    end
  end

  // ---------------------------------------------------------------- stage 2
  logic signed [ACC_W-1:0] integ_q, integ_d;
  logic signed [ACC_W-1:0] w_integ_base;
  logic signed [SUM_W-1:0] w_acc_sum;
  logic signed [ACC_W-1:0] w_acc_sat;
  logic signed [SUM_W-1:0] sum_d, sum_q;
  logic                    v2_q;
  logic                    w_hold;
  logic                    sat_hi_q, sat_lo_q;

`ifdef PI_ANTIWINDUP_EN
  logic w_i_pos;
  logic w_i_neg;
  assign w_i_neg = i_prod_q[PROD_W-1];
  assign w_i_pos = ~i_prod_q[PROD_W-1] & (|i_prod_q);
  // Flags are the registered ones, so they lag the newest output by design.
  assign w_hold  = (sat_hi_q & w_i_pos) | (sat_lo_q & w_i_neg);
`else
  assign w_hold  = 1'b0;
`endif

  // Integrator update: a clear zeroes the old value first, then a sample in
  // this stage accumulates on top of zero. The add saturates instead of wrapping.
  always_comb begin
    w_integ_base = clear_int ? '0 : integ_q;
    w_acc_sum    = SUM_W'(w_integ_base) + SUM_W'(i_prod_q);
    if (w_acc_sum[SUM_W-1] != w_acc_sum[SUM_W-2]) begin
      w_acc_sat = w_acc_sum[SUM_W-1] ? C_ACC_MIN : C_ACC_MAX;
    end else begin
      w_acc_sat = w_acc_sum[ACC_W-1:0];
    end
    if (v1_q && !w_hold) begin
      integ_d = w_acc_sat;
    end else begin
      integ_d = w_integ_base;
    end
    sum_d = SUM_W'(p_prod_q) + SUM_W'(integ_d);
  end

  // Integrator and the P+I sum advance together with the stage-1 valid bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      integ_q <= '0;
      sum_q   <= '0;
      v2_q    <= 1'b0;
    end else begin
      integ_q <= integ_d;
      v2_q    <= v1_q;
      if (v1_q) begin
        sum_q <= sum_d;
      end
    end
  end

  // ---------------------------------------------------------------- stage 3
  logic signed [SUM_W-1:0]  w_shifted;
  logic signed [DATA_W-1:0] out_d;
  logic                     sat_hi_d, sat_lo_d;
  logic signed [DATA_W-1:0] out_q;
  logic                     out_valid_q;

  // Floor-rescale the sum and clamp it to the output range.
  always_comb begin
    w_shifted = sum_q >>> FRAC_W;
    sat_hi_d  = 1'b0;
    sat_lo_d  = 1'b0;
    if (w_shifted > C_OUT_MAX_X) begin
      out_d    = OUT_MAX;
      sat_hi_d = 1'b1;
    end else if (w_shifted < C_OUT_MIN_X) begin
      out_d    = OUT_MIN;
      sat_lo_d = 1'b1;
    end else begin
      out_d = w_shifted[DATA_W-1:0];
    end
  end

  // Output register: value and flags hold between strobes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q       <= '0;
      sat_hi_q    <= 1'b0;
      sat_lo_q    <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      out_valid_q <= v2_q;
      if (v2_q) begin
        out_q    <= out_d;
        sat_hi_q <= sat_hi_d;
        sat_lo_q <= sat_lo_d;
      end
    end
  end

  assign out       = out_q;
  assign out_valid = out_valid_q;
  assign sat_hi    = sat_hi_q;
  assign sat_lo    = sat_lo_q;

endmodule
`default_nettype wire

// File: tb/tb_pi_controller_sat.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pi_controller_sat
//  Purpose  : Directed self-checking bench for pi_controller_sat, run with
//             OUT_MAX=1000 and OUT_MIN=-1000. Expected values are worked out
//             by hand. The anti-windup case follows PI_ANTIWINDUP_EN.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_pi_controller_sat;

  logic               clk;
  logic               rst;
  logic               in_valid;
  logic signed [31:0] error;
  logic signed [15:0] kp;
  logic signed [15:0] ki;
  logic               clear_int;
  logic               out_valid;
  logic signed [31:0] out;
  logic               sat_hi;
  logic               sat_lo;

  int n_vec;
  int n_err;

  pi_controller_sat #(
    .DATA_W (32),
    .COEF_W (16),
    .FRAC_W (8),
    .ACC_W  (48),
    .OUT_MAX(32'sd1000),
    .OUT_MIN(-32'sd1000)
  ) u_dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .error    (error),
    .kp       (kp),
    .ki       (ki),
    .clear_int(clear_int),
    .out_valid(out_valid),
    .out      (out),
    .sat_hi   (sat_hi),
    .sat_lo   (sat_lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance past one rising edge and settle away from it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, $signed(obs), $signed(exp));
    end
  endtask

  // Present one sample for one cycle, wait out the latency, then check.
  task automatic one_sample(input string tag, input int e, input int gp, input int gi,
                            input int exp_out, input bit exp_hi, input bit exp_lo);
    error    = 32'(e);
    kp       = 16'(gp);
    ki       = 16'(gi);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    chk({tag, "_out"}, out, 32'(exp_out));
    chk({tag, "_ov"}, {31'd0, out_valid}, 32'd1);
    chk({tag, "_hi"}, {31'd0, sat_hi}, {31'd0, exp_hi});
    chk({tag, "_lo"}, {31'd0, sat_lo}, {31'd0, exp_lo});
    tick();
  endtask

  initial begin
    int  sat_out [6];
    bit  sat_hif [6];

    n_vec     = 0;
    n_err     = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    error     = '0;
    kp        = '0;
    ki        = '0;
    clear_int = 1'b0;

    // Reset state.
    #3;
    chk("rst_out", out, 32'd0);
    chk("rst_ov", {31'd0, out_valid}, 32'd0);
    chk("rst_hi", {31'd0, sat_hi}, 32'd0);
    chk("rst_lo", {31'd0, sat_lo}, 32'd0);
    tick();
    rst = 1'b0;
    tick();

    // Proportional pulse: latency and single-cycle strobe.
    error    = 32'sd100;
    kp       = 16'sd256;
    ki       = 16'sd0;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    chk("p1_early_ov", {31'd0, out_valid}, 32'd0);
    tick();
    chk("p1_out", out, 32'd100);
    chk("p1_ov", {31'd0, out_valid}, 32'd1);
    chk("p1_hi", {31'd0, sat_hi}, 32'd0);
    chk("p1_lo", {31'd0, sat_lo}, 32'd0);
    tick();
    chk("p1_ov_drop", {31'd0, out_valid}, 32'd0);
    chk("p1_hold", out, 32'd100);

    // Floor on negative: -3*128 = -384, >>>8 = -2.
    one_sample("p_floor", -3, 128, 0, -2, 1'b0, 1'b0);

    // Integral accumulation, back-to-back samples.
    kp    = 16'sd0;
    ki    = 16'sd256;
    error = 32'sd10;
    for (int t = 0; t < 7; t++) begin
      in_valid = (t < 5);
      tick();
      if (t >= 2) begin
        chk($sformatf("i_acc%0d", t - 2), out, 32'(10 * (t - 1)));
        chk($sformatf("i_ov%0d", t - 2), {31'd0, out_valid}, 32'd1);
      end
    end
    in_valid = 1'b0;
    tick();
    chk("i_ov_end", {31'd0, out_valid}, 32'd0);

    // Clear integrator with no sample in flight.
    clear_int = 1'b1;
    tick();
    clear_int = 1'b0;

    // Saturation and anti-windup; samples spaced four cycles.
    sat_out = '{300, 600, 900, 1000, 1000, 1000};
    sat_hif = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
`ifdef PI_ANTIWINDUP_EN
    sat_out[5] = 900;
    sat_hif[5] = 1'b0;
`endif
    for (int s = 0; s < 6; s++) begin
      one_sample($sformatf("sat%0d", s), (s < 5) ? 300 : -300, 0, 256,
                 sat_out[s], sat_hif[s], 1'b0);
    end

    // Bring integrator to 500, then clear in the cycle a sample is in S2.
    clear_int = 1'b1;
    tick();
    clear_int = 1'b0;
    one_sample("clr_pre", 500, 0, 256, 500, 1'b0, 1'b0);
    error    = 32'sd10;
    ki       = 16'sd256;
    in_valid = 1'b1;
    tick();
    in_valid  = 1'b0;
    clear_int = 1'b1;
    tick();
    clear_int = 1'b0;
    tick();
    chk("clr_out", out, 32'd10);
    chk("clr_ov", {31'd0, out_valid}, 32'd1);
    tick();
    one_sample("clr_next", 10, 0, 256, 20, 1'b0, 1'b0);

    // Asynchronous reset with three samples in flight.
    error    = 32'sd10;
    ki       = 16'sd256;
    in_valid = 1'b1;
    tick();
    tick();
    #2;
    rst = 1'b1;
    #1;
    chk("arst_out", out, 32'd0);
    chk("arst_ov", {31'd0, out_valid}, 32'd0);
    chk("arst_hi", {31'd0, sat_hi}, 32'd0);
    chk("arst_lo", {31'd0, sat_lo}, 32'd0);
    in_valid = 1'b0;
    tick();
    rst = 1'b0;
    for (int t = 0; t < 5; t++) begin
      tick();
      chk($sformatf("arst_quiet%0d", t), {31'd0, out_valid}, 32'd0);
    end
    one_sample("arst_fresh", 10, 0, 256, 10, 1'b0, 1'b0);

    // Negative clamp through the proportional path.
    one_sample("neg_clamp", -5000, 256, 0, -1000, 1'b0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
